// File: rtl/contador_ctrl.sv
// contador_ctrl: readout sequencer for the push-counter bank.
//   On start it waits for the FIFOs to drain, then sweeps idx 0..NUM_CNT-1.
//   It issues one req per index and turns each returned count into a one-cycle
//   cnt_valid pulse tagged with its index. An index that does not answer
//   within TIMEOUT cycles is skipped and sets the sticky error flag.
// Ports:
//   clk, reset              clock / async active-high reset
//   start, idle             sweep request / bank FIFOs empty
//   data_in, valid_in       count returned by the bank
//   req_out, idx_out        read request and index to the bank
//   cnt_data, cnt_idx,
//   cnt_valid               captured result and its one-cycle qualifier
//   busy, done, error       sweep status
module contador_ctrl #(
    parameter int NUM_CNT = 5,
    parameter int DATA_W  = 6,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              idle,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              req_out,
    output logic [IDX_W-1:0]  idx_out,
    output logic [DATA_W-1:0] cnt_data,
    output logic [IDX_W-1:0]  cnt_idx,
    output logic              cnt_valid,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_REQ,
        S_WAIT_VALID,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] cnt_data_q, cnt_data_d;
    logic [IDX_W-1:0]  cnt_idx_q, cnt_idx_d;
    logic              cnt_valid_q, cnt_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              leave_wait;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        timer_d     = timer_q;
        cnt_data_d  = cnt_data_q;
        cnt_idx_d   = cnt_idx_q;
        cnt_valid_d = 1'b0;
        error_d     = error_q;
        leave_wait  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_IDLE;
                    error_d = 1'b0;
                    index_d = '0;
                end
            end
            S_WAIT_IDLE: begin
                if (idle) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT_VALID;
                timer_d = '0;
            end
            S_WAIT_VALID: begin
                timer_d = timer_q + TMR_W'(1);
                // A capture on the last timer cycle wins over the timeout.
                if (valid_in) begin
                    cnt_data_d  = data_in;
                    cnt_idx_d   = index_q;
                    cnt_valid_d = 1'b1;
                    leave_wait  = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    error_d    = 1'b1;
                    leave_wait = 1'b1;
                end
                if (leave_wait) begin
                    if (index_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so that the
        // registered versions line up with the state they describe.
        req_d  = (state_d == S_REQ);
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            timer_q     <= '0;
            req_q       <= 1'b0;
            cnt_data_q  <= '0;
            cnt_idx_q   <= '0;
            cnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            cnt_data_q  <= cnt_data_d;
            cnt_idx_q   <= cnt_idx_d;
            cnt_valid_q <= cnt_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // index_q is a flop and already holds the value the bank needs in both
    // REQ and WAIT_VALID, so it drives idx_out directly.
    assign req_out   = req_q;
    assign idx_out   = index_q;
    assign cnt_data  = cnt_data_q;
    assign cnt_idx   = cnt_idx_q;
    assign cnt_valid = cnt_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge; a small bank responder answers each req after a
// programmable number of cycles and can be told to ignore one index.
module tb_contador_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       idle;
    logic [5:0] data_in;
    logic       valid_in;
    logic       req_out;
    logic [2:0] idx_out;
    logic [5:0] cnt_data;
    logic [2:0] cnt_idx;
    logic       cnt_valid;
    logic       busy;
    logic       done;
    logic       error;

    contador_ctrl #(.NUM_CNT(5), .DATA_W(6), .IDX_W(3), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .idle(idle),
        .data_in(data_in), .valid_in(valid_in),
        .req_out(req_out), .idx_out(idx_out),
        .cnt_data(cnt_data), .cnt_idx(cnt_idx), .cnt_valid(cnt_valid),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int n_done = 0;
    int done_tick = 0;
    int bank_lat = 1;
    int skip_idx = -1;
    bit spur = 1'b0;
    bit pend_armed = 1'b0;
    int pend_cnt = 0;
    int pend_idx = 0;
    int cap_idx[$];
    int cap_dat[$];
    int req_tick[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr();
        cap_idx.delete();
        cap_dat.delete();
        req_tick.delete();
        n_done = 0;
    endtask

    // One clock: sample outputs at negedge, then drive the inputs the DUT
    // will see at the next rising edge (i.e. in the state just observed).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cnt_valid) begin
            cap_idx.push_back(int'(cnt_idx));
            cap_dat.push_back(int'(cnt_data));
        end
        if (done) begin
            n_done++;
            done_tick = cyc;
        end
        valid_in = spur;
        data_in  = 6'(int'(idx_out) + 20);
        if (pend_armed) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend_armed = 1'b0;
                if (pend_idx != skip_idx) begin
                    valid_in = 1'b1;
                    data_in  = 6'(pend_idx + 10);
                end
            end
        end
        if (req_out) begin
            req_tick.push_back(cyc);
            pend_armed = 1'b1;
            pend_cnt   = bank_lat;
            pend_idx   = int'(idx_out);
        end
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int d0;
        int n;
        d0 = n_done;
        n  = 0;
        while (n_done == d0 && n < bound) begin
            tick();
            n++;
        end
        chk("done_reached", int'(n_done > d0), 1);
    endtask

    initial begin
        int s;
        int t;
        int n;

        reset = 1'b1; start = 1'b0; idle = 1'b0; valid_in = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_req", int'(req_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_cval", int'(cnt_valid), 0);
        chk("rst_idx", int'(idx_out), 0);
        chk("rst_cdat", int'(cnt_data), 0);
        reset = 1'b0;
        tick();

        // Plain sweep, bank answers one cycle after each req with idx+10.
        clr();
        idle = 1'b1;
        pulse_start(s);
        wait_done(60);
        chk("t2_first_req", req_tick.size() > 0 ? req_tick[0] - s : -1, 2);
        chk("t2_done_lat", done_tick - s, 12);
        chk("t2_ncap", cap_idx.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_cidx", i < cap_idx.size() ? cap_idx[i] : -1, i);
            chk("t2_cdat", i < cap_dat.size() ? cap_dat[i] : -1, i + 10);
        end
        chk("t2_err", int'(error), 0);
        tick();
        chk("t2_idle_busy", int'(busy), 0);
        chk("t2_hold_cdat", int'(cnt_data), 14);

        // FIFOs not idle for a while after start.
        clr();
        idle = 1'b0;
        pulse_start(s);
        repeat (5) tick();
        chk("t3_noreq", req_tick.size(), 0);
        chk("t3_busy", int'(busy), 1);
        idle = 1'b1;
        t = cyc;
        tick();
        chk("t3_req", int'(req_out), 1);
        chk("t3_req_lat", req_tick.size() > 0 ? req_tick[0] - t : -1, 1);
        wait_done(60);
        chk("t3_ncap", cap_idx.size(), 5);

        // Index 3 never answers.
        tick();
        clr();
        skip_idx = 3;
        pulse_start(s);
        wait_done(80);
        chk("t4_nreq", req_tick.size(), 5);
        chk("t4_gap", req_tick.size() == 5 ? req_tick[4] - req_tick[3] : -1, 9);
        chk("t4_ncap", cap_idx.size(), 4);
        chk("t4_cidx3", cap_idx.size() > 3 ? cap_idx[3] : -1, 4);
        chk("t4_cdat3", cap_dat.size() > 3 ? cap_dat[3] : -1, 14);
        chk("t4_err", int'(error), 1);
        skip_idx = -1;
        tick();

        // Spurious valid in IDLE, then start held through a sweep.
        clr();
        spur = 1'b1;
        repeat (3) begin
            tick();
            chk("t5_spur_idle", int'(cnt_valid), 0);
        end
        start = 1'b1;
        tick();
        chk("t5_err_clr", int'(error), 0);
        wait_done(60);
        tick();
        chk("t5_idle_visit", int'(busy), 0);
        tick();
        chk("t5_restart", int'(busy), 1);
        start = 1'b0;
        wait_done(60);
        tick();
        chk("t5_end_busy", int'(busy), 0);
        tick();
        chk("t5_no_queue", int'(busy), 0);
        chk("t5_ndone", n_done, 2);
        chk("t5_ncap", cap_idx.size(), 10);
        n = 0;
        for (int i = 0; i < cap_idx.size(); i++)
            if (cap_dat[i] != cap_idx[i] + 10 || cap_idx[i] != i % 5) n++;
        chk("t5_cap_bad", n, 0);
        spur = 1'b0;

        // Answer exactly on the last timer cycle.
        clr();
        bank_lat = 8;
        pulse_start(s);
        wait_done(150);
        chk("t6_ncap", cap_idx.size(), 5);
        chk("t6_cdat4", cap_dat.size() == 5 ? cap_dat[4] : -1, 14);
        chk("t6_err", int'(error), 0);
        bank_lat = 1;
        tick();

        // Reset in the middle of a sweep, while waiting on idx 2.
        clr();
        pulse_start(s);
        n = 0;
        while (!(req_out && idx_out == 3'd2) && n < 20) begin
            tick();
            n++;
        end
        chk("t1_reach_idx2", int'(req_out && idx_out == 3'd2), 1);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("t1_req", int'(req_out), 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_err", int'(error), 0);
        chk("t1_idx", int'(idx_out), 0);
        #1 reset = 1'b0;
        pend_armed = 1'b0;
        valid_in   = 1'b0;
        tick();
        chk("t1_stay_idle", int'(busy), 0);
        clr();
        pulse_start(s);
        tick();
        chk("t1_restart_req", int'(req_out), 1);
        wait_done(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
